// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types and constants for the TDM receive demultiplexer
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  // Slot index width; never below one bit so the counter always has storage.
  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - shared-line input and per-channel output bundle of tdm_demux
interface tdm_demux_if #(
  parameter int N_CH = tdm_pkg::DEF_N_CH,
  parameter int W    = tdm_pkg::DEF_W
);

  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] dout;
  logic [N_CH-1:0]   dout_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot counter with load-to-one, increment and wrap at N_CH-1
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load1,
  input  logic                      inc,
  output logic [slot_w(N_CH)-1:0]   slot,
  output logic                      terminal
);

  localparam int SW = slot_w(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  assign terminal = (slot == LAST);

  // Wrap comes from the terminal compare, so non-power-of-two N_CH is exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (inc) begin
      slot <= terminal ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demultiplexer; TDM_DEMUX_FRAME_LATCH_EN selects whole-frame output update
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int SW = slot_w(N_CH);

  tdm_state_t     state;
  tdm_state_t     state_next;
  logic [SW-1:0]  slot;
  logic           terminal;

  logic           wr_en;
  logic [SW-1:0]  wr_ch;
  logic           ctr_load1;
  logic           ctr_inc;
  logic           frame_done_next;
  logic           sync_err_next;

  logic [W-1:0]    ch_q [N_CH];
  logic [N_CH-1:0] dout_valid_q;
  logic            frame_done_q;
  logic            sync_err_q;

  tdm_slot_ctr #(.N_CH(N_CH)) u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load1    (ctr_load1),
    .inc      (ctr_inc),
    .slot     (slot),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Only reset returns the block to HUNT; a misplaced sync just realigns.
  always_comb begin
    state_next = state;
    if (state == HUNT && bus.din_valid && bus.frame_sync) begin
      state_next = LOCKED;
    end
  end

  always_comb begin
    wr_en           = 1'b0;
    wr_ch           = '0;
    ctr_load1       = 1'b0;
    ctr_inc         = 1'b0;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en     = 1'b1;
            ctr_load1 = 1'b1;
          end
        end
        LOCKED: begin
          if (bus.frame_sync && slot != '0) begin
            sync_err_next = 1'b1;
            wr_en         = 1'b1;
            ctr_load1     = 1'b1;
          end else begin
            wr_en           = 1'b1;
            wr_ch           = slot;
            ctr_inc         = 1'b1;
            frame_done_next = terminal;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [W-1:0] shadow_q [N_CH];

  // Slots collect in the shadow bank; the final slot bypasses it on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        shadow_q[k] <= '0;
        ch_q[k]     <= '0;
      end
      dout_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= '0;
      frame_done_q <= frame_done_next;
      sync_err_q   <= sync_err_next;
      if (wr_en) begin
        if (sync_err_next) begin
          for (int k = 1; k < N_CH; k++) begin
            shadow_q[k] <= '0;
          end
        end
        shadow_q[wr_ch] <= bus.din;
      end
      if (frame_done_next) begin
        for (int k = 0; k < N_CH; k++) begin
          ch_q[k] <= (SW'(k) == wr_ch) ? bus.din : shadow_q[k];
        end
        dout_valid_q <= '1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        ch_q[k] <= '0;
      end
      dout_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= '0;
      frame_done_q <= frame_done_next;
      sync_err_q   <= sync_err_next;
      if (wr_en) begin
        ch_q[wr_ch]         <= bus.din;
        dout_valid_q[wr_ch] <= 1'b1;
      end
    end
  end
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_dout
    assign bus.dout[k*W +: W] = ch_q[k];
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux against a frame-level reference model
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  typedef struct {
    logic [N_CH*W-1:0] dout;
    logic [N_CH-1:0]   dv;
    logic              fd;
    logic              se;
  } ev_t;

  typedef struct {
    logic [N_CH*W-1:0] dout;
    logic              locked;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ev_t  ev_q [$];
  cyc_t cyc_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit           m_locked;
  int           m_slot;
  logic [W-1:0] m_ch [N_CH];
  logic [W-1:0] m_sh [N_CH];

  function automatic logic [N_CH*W-1:0] pack_ch();
    logic [N_CH*W-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*W +: W] = m_ch[k];
    return v;
  endfunction

  task automatic step(input bit rst, input bit v, input bit fs, input logic [W-1:0] d);
    logic [N_CH-1:0] dv;
    bit fd;
    bit se;
    int tgt;
    ev_t e;
    cyc_t c;
    @(negedge clk);
    rst_n          = !rst;
    bus.din_valid  = v;
    bus.frame_sync = fs;
    bus.din        = d;
    dv = '0; fd = 0; se = 0; tgt = -1;
    if (rst) begin
      m_locked = 0;
      m_slot   = 0;
      for (int k = 0; k < N_CH; k++) begin m_ch[k] = '0; m_sh[k] = '0; end
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin m_locked = 1; tgt = 0; m_slot = 1; end
      end else if (fs && m_slot != 0) begin
        se = 1; tgt = 0; m_slot = 1;
        for (int k = 0; k < N_CH; k++) m_sh[k] = '0;
      end else begin
        tgt = m_slot;
        if (m_slot == N_CH - 1) begin fd = 1; m_slot = 0; end
        else m_slot = m_slot + 1;
      end
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      if (tgt >= 0) m_sh[tgt] = d;
      if (fd) begin
        for (int k = 0; k < N_CH; k++) m_ch[k] = m_sh[k];
        dv = '1;
      end
`else
      if (tgt >= 0) begin m_ch[tgt] = d; dv[tgt] = 1'b1; end
`endif
    end
    c.dout = pack_ch(); c.locked = m_locked;
    cyc_q.push_back(c);
    if (dv != 0 || fd || se) begin
      e.dout = c.dout; e.dv = dv; e.fd = fd; e.se = se;
      ev_q.push_back(e);
    end
  endtask

  // Monitor: per-cycle state check plus a pop whenever the DUT emits a strobe.
  always @(posedge clk) begin
    cyc_t c;
    ev_t  e;
    #1;
    if (cyc_q.size() != 0) begin
      c = cyc_q.pop_front();
      n_tests++;
      if (bus.locked !== c.locked || bus.dout !== c.dout) begin
        n_fail++;
        $display("FAIL cycle_state: got locked=%b dout=%h want locked=%b dout=%h",
                 bus.locked, bus.dout, c.locked, c.dout);
      end
      if (bus.dout_valid !== '0 || bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0) begin
        n_tests++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got dv=%b fd=%b se=%b want none",
                   bus.dout_valid, bus.frame_done, bus.sync_err);
        end else begin
          e = ev_q.pop_front();
          if (bus.dout_valid !== e.dv || bus.frame_done !== e.fd ||
              bus.sync_err !== e.se || bus.dout !== e.dout) begin
            n_fail++;
            $display("FAIL strobe_event: got dv=%b fd=%b se=%b dout=%h want dv=%b fd=%b se=%b dout=%h",
                     bus.dout_valid, bus.frame_done, bus.sync_err, bus.dout,
                     e.dv, e.fd, e.se, e.dout);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1), W'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h11);
    step(0, 1, 1, 8'hA0); step(0, 1, 0, 8'hA1); step(0, 1, 0, 8'hA2); step(0, 1, 0, 8'hA3);
    for (int i = 0; i < N_CH; i++) begin
      step(0, 1, i == 0, 8'hA0 + 8'(i) + 8'h10);
      idle(2);
    end
    step(0, 1, 1, 8'hB0); step(0, 1, 0, 8'hB1);
    step(0, 1, 1, 8'hC0); step(0, 1, 0, 8'hC1); step(0, 1, 0, 8'hC2); step(0, 1, 0, 8'hC3);
    step(0, 1, 1, 8'hA0); step(0, 1, 0, 8'hA1); step(0, 1, 0, 8'hA2);
    step(1, 1, 0, 8'h55);
    step(0, 1, 0, 8'h66);
    step(0, 1, 1, 8'hD0); step(0, 1, 0, 8'hD1); step(0, 1, 0, 8'hD2); step(0, 1, 0, 8'hD3);
    for (int i = 0; i < 3000; i++) begin
      bit r, v, fs;
      r  = ($urandom % 150) == 0;
      v  = ($urandom % 4) != 0;
      fs = m_locked ? (($urandom % 10) == 0) : (($urandom % 3) == 0);
      step(r, v, fs, W'($urandom));
    end
    step(0, 0, 0, 8'h00);
    @(posedge clk); @(posedge clk); #2;
    n_tests++;
    if (ev_q.size() != 0 || cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d events %0d cycles pending want 0 0", ev_q.size(), cyc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
